// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants and types for the ALU op sequencer
package alu_pkg;

  localparam int DATA_W  = 4;
  localparam int INSTR_W = 10;
  localparam int NUM_REGS = 4;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  // Instruction field bit positions; imm overlays rs1/rs2 when ld_imm is set.
  localparam int I_LD_IMM = 9;
  localparam int I_OP_HI  = 8;
  localparam int I_OP_LO  = 7;
  localparam int I_RD_HI  = 6;
  localparam int I_RD_LO  = 5;
  localparam int I_RS1_HI = 4;
  localparam int I_RS1_LO = 3;
  localparam int I_RS2_HI = 2;
  localparam int I_RS2_LO = 1;
  localparam int I_IMM_HI = 4;
  localparam int I_IMM_LO = 1;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_EXEC  = 1'b1
  } state_t;

  function automatic logic op_sets_carry(input logic [1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_instr_fifo.sv
// rtl/alu_instr_fifo.sv - synchronous show-ahead instruction FIFO with full/empty
module alu_instr_fifo
  import alu_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int WIDTH      = INSTR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - instruction issue stage feeding a 4-bit ALU; ALU_SEQ_PERF_EN adds retired_count
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [9:0]        instr,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [1:0]        alu_op_code,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry_out,
  output logic              retire_valid,
  output logic [1:0]        retire_rd,
  output logic [DATA_W-1:0] retire_data,
  output logic              carry_flag,
  output logic              zero_flag
`ifdef ALU_SEQ_PERF_EN
  ,
  output logic [15:0]       retired_count
`endif
);

  state_t             state;
  logic [INSTR_W-1:0] ir;
  logic [DATA_W-1:0]  rf [NUM_REGS];

  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic               fifo_push;
  logic [INSTR_W-1:0] head;

  assign instr_ready = !rst && !fifo_full;
  assign fifo_push   = instr_valid && instr_ready;
  assign fifo_pop    = (state == ST_FETCH) && !fifo_empty;

  alu_instr_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (INSTR_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (instr),
    .pop       (fifo_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // ALU operands are registered at the pop edge; no writeback happens on that
  // edge, so the register file values captured there are the EXEC-cycle values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_FETCH;
      ir           <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        rf[i] <= '0;
      end
      alu_a        <= '0;
      alu_b        <= '0;
      alu_op_code  <= '0;
      retire_valid <= 1'b0;
      retire_rd    <= '0;
      retire_data  <= '0;
      carry_flag   <= 1'b0;
      zero_flag    <= 1'b0;
    end else begin
      retire_valid <= 1'b0;
      case (state)
        ST_FETCH: begin
          if (!fifo_empty) begin
            ir    <= head;
            state <= ST_EXEC;
            if (!head[I_LD_IMM]) begin
              alu_a       <= rf[head[I_RS1_HI:I_RS1_LO]];
              alu_b       <= rf[head[I_RS2_HI:I_RS2_LO]];
              alu_op_code <= head[I_OP_HI:I_OP_LO];
            end
          end
        end
        ST_EXEC: begin
          state        <= ST_FETCH;
          alu_a        <= '0;
          alu_b        <= '0;
          alu_op_code  <= '0;
          retire_valid <= 1'b1;
          retire_rd    <= ir[I_RD_HI:I_RD_LO];
          if (ir[I_LD_IMM]) begin
            rf[ir[I_RD_HI:I_RD_LO]] <= ir[I_IMM_HI:I_IMM_LO];
            retire_data             <= ir[I_IMM_HI:I_IMM_LO];
          end else begin
            rf[ir[I_RD_HI:I_RD_LO]] <= alu_result;
            retire_data             <= alu_result;
            zero_flag               <= (alu_result == '0);
            carry_flag              <= op_sets_carry(ir[I_OP_HI:I_OP_LO]) ? alu_carry_out : 1'b0;
          end
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

`ifdef ALU_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_count <= '0;
    end else if (retire_valid) begin
      retired_count <= retired_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - scoreboard bench for alu_op_sequencer with a behavioural ALU
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [9:0] instr;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [1:0] alu_op_code;
  logic [3:0] alu_result;
  logic       alu_carry_out;
  logic       retire_valid;
  logic [1:0] retire_rd;
  logic [3:0] retire_data;
  logic       carry_flag;
  logic       zero_flag;
`ifdef ALU_SEQ_PERF_EN
  logic [15:0] retired_count;
`endif

  alu_op_sequencer #(.FIFO_DEPTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_op_code   (alu_op_code),
    .alu_result    (alu_result),
    .alu_carry_out (alu_carry_out),
    .retire_valid  (retire_valid),
    .retire_rd     (retire_rd),
    .retire_data   (retire_data),
    .carry_flag    (carry_flag),
    .zero_flag     (zero_flag)
`ifdef ALU_SEQ_PERF_EN
    ,
    .retired_count (retired_count)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for advanced_alu_4bit.
  always_comb begin
    alu_result    = 4'd0;
    alu_carry_out = 1'b0;
    case (alu_op_code)
      2'b00: {alu_carry_out, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
      2'b01: begin
        alu_result    = alu_a - alu_b;
        alu_carry_out = (alu_a >= alu_b);
      end
      2'b10: alu_result = alu_a & alu_b;
      default: alu_result = alu_a | alu_b;
    endcase
  end

  typedef struct {
    logic [1:0] rd;
    logic [3:0] data;
    logic       carry;
    logic       zero;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_retire_cyc = 0;
  int burst_retires = 0;
  int retire_total = 0;
  bit burst = 0;
  bit saw_not_ready = 0;
  logic prev_rv = 1'b0;
  logic [3:0] prev_a = 4'd0;
  logic [3:0] prev_b = 4'd0;
  logic [1:0] prev_op = 2'd0;

  logic [3:0] m_r [4];
  logic       m_c;
  logic       m_z;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] mk_alu(input logic [1:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs1, input logic [1:0] rs2);
    return {1'b0, op, rd, rs1, rs2, 1'b0};
  endfunction

  function automatic logic [9:0] mk_ld(input logic [1:0] rd, input logic [3:0] imm);
    return {1'b1, 2'b00, rd, imm, 1'b0};
  endfunction

  // Reference model: computes the expected retire for a word at acceptance time.
  task automatic model_push(input logic [9:0] w);
    exp_t e;
    logic [4:0] s;
    e.rd = w[6:5];
    e.a = 4'd0; e.b = 4'd0; e.op = 2'd0;
    if (w[9]) begin
      e.data = w[4:1];
    end else begin
      e.a = m_r[w[4:3]];
      e.b = m_r[w[2:1]];
      e.op = w[8:7];
      case (w[8:7])
        2'b00: begin s = {1'b0, e.a} + {1'b0, e.b}; e.data = s[3:0]; m_c = s[4]; end
        2'b01: begin e.data = e.a - e.b; m_c = (e.a >= e.b); end
        2'b10: begin e.data = e.a & e.b; m_c = 1'b0; end
        default: begin e.data = e.a | e.b; m_c = 1'b0; end
      endcase
      m_z = (e.data == 4'd0);
    end
    m_r[e.rd] = e.data;
    e.carry = m_c;
    e.zero = m_z;
    sb.push_back(e);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_r[i] = 4'd0;
    m_c = 1'b0;
    m_z = 1'b0;
    sb.delete();
  endtask

  task automatic send(input logic [9:0] w);
    int t = 0;
    @(negedge clk);
    instr = w;
    instr_valid = 1'b1;
    while (!instr_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!instr_ready) begin
      chk("send_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge clk);
      model_push(w);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain", sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      retire_total = 0;
    end else begin
      if (burst && instr_valid && !instr_ready) saw_not_ready = 1;
      if (retire_valid) begin
        exp_t e;
        retire_total++;
        chk("retire_one_cycle", prev_rv, 1'b0);
        if (sb.size() == 0) begin
          chk("unexpected_retire", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("retire_rd", retire_rd, e.rd);
          chk("retire_data", retire_data, e.data);
          chk("carry_flag", carry_flag, e.carry);
          chk("zero_flag", zero_flag, e.zero);
          chk("exec_alu_a", prev_a, e.a);
          chk("exec_alu_b", prev_b, e.b);
          chk("exec_alu_op", prev_op, e.op);
        end
        if (burst) begin
          if (burst_retires > 0) chk("retire_spacing", cyc - last_retire_cyc, 2);
          burst_retires++;
        end
        last_retire_cyc = cyc;
      end
    end
    prev_rv = retire_valid;
    prev_a = alu_a;
    prev_b = alu_b;
    prev_op = alu_op_code;
  end

  initial begin
    rst = 1'b1;
    instr_valid = 1'b0;
    instr = 10'd0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_instr_ready", instr_ready, 1'b0);
    chk("rst_retire_valid", retire_valid, 1'b0);
    chk("rst_flags", {carry_flag, zero_flag}, 2'b00);
    chk("rst_alu_out", {alu_a, alu_b, alu_op_code}, 10'd0);
    chk("rst_retire_out", {retire_rd, retire_data}, 6'd0);
`ifdef ALU_SEQ_PERF_EN
    chk("rst_retired_count", retired_count, 16'd0);
`endif
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", instr_ready, 1'b1);

    send(mk_ld(2'd0, 4'd7));
    send(mk_ld(2'd1, 4'd3));
    send(mk_alu(2'b00, 2'd2, 2'd0, 2'd1));
    send(mk_alu(2'b01, 2'd3, 2'd0, 2'd1));
    send(mk_alu(2'b10, 2'd2, 2'd0, 2'd1));
    send(mk_alu(2'b11, 2'd2, 2'd0, 2'd1));
    idle();
    drain();

    send(mk_ld(2'd0, 4'd15));
    send(mk_ld(2'd1, 4'd1));
    send(mk_alu(2'b00, 2'd2, 2'd0, 2'd1));
    send(mk_alu(2'b10, 2'd3, 2'd0, 2'd1));
    send(mk_alu(2'b11, 2'd3, 2'd0, 2'd1));
    send(mk_alu(2'b01, 2'd3, 2'd1, 2'd0));
    idle();
    drain();

    burst = 1;
    burst_retires = 0;
    send(mk_ld(2'd0, 4'd5));
    send(mk_alu(2'b00, 2'd1, 2'd0, 2'd0));
    send(mk_alu(2'b01, 2'd2, 2'd1, 2'd0));
    send(mk_alu(2'b11, 2'd3, 2'd2, 2'd1));
    idle();
    drain();
    burst = 0;
    chk("burst_backpressure", saw_not_ready, 1'b1);
    chk("burst_retire_count", burst_retires, 4);

    send(mk_alu(2'b00, 2'd2, 2'd0, 2'd1));
    @(negedge clk);
    instr_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    chk("midexec_no_retire", retire_valid, 1'b0);
    chk("midexec_ready_low", instr_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_retire", retire_valid, 1'b0);
    chk("post_rst_flags", {carry_flag, zero_flag}, 2'b00);
    chk("post_rst_ready", instr_ready, 1'b1);

    send(mk_alu(2'b11, 2'd2, 2'd2, 2'd2));
    send(mk_ld(2'd1, 4'd9));
    send(mk_alu(2'b00, 2'd3, 2'd1, 2'd1));
    idle();
    drain();
`ifdef ALU_SEQ_PERF_EN
    chk("retired_count", retired_count, retire_total);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
